// File: rtl/tone_pkg.sv
// Shared types and constants for the four-channel tone generator.
package tone_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        NOISE  = 2'd3
    } wave_e;

    // Register index as decoded from addr[4:2]
    localparam logic [2:0] CH0  = 3'd0;
    localparam logic [2:0] CH1  = 3'd1;
    localparam logic [2:0] CH2  = 3'd2;
    localparam logic [2:0] CH3  = 3'd3;
    localparam logic [2:0] CTRL = 3'd4;

    localparam logic [14:0] LFSR_SEED  = 15'h0001;
    localparam logic [7:0]  SAMPLE_MID = 8'h80;

endpackage

// File: rtl/tone_channel.sv
// One tone voice: 16-bit phase accumulator, 15-bit noise LFSR and wave shaper
// with a registered unsigned 8-bit sample output.
module tone_channel
    import tone_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        clr,
    input  logic [15:0] freq,
    input  wave_e       wave,
    input  logic        en,
    output logic [7:0]  sample
);

    logic [15:0] phase;
    logic [14:0] lfsr;
    logic [16:0] sum;

    assign sum = {1'b0, phase} + {1'b0, freq};

    function automatic logic [7:0] shape(input wave_e w, input logic [15:0] ph,
                                         input logic [7:0] lf);
        case (w)
            SQUARE:  shape = ph[15] ? 8'hFF : 8'h00;
            SAW:     shape = ph[15:8];
            TRI:     shape = ph[15] ? ~ph[14:7] : ph[14:7];
            default: shape = lf;
        endcase
    endfunction

    // Clear and disable both dominate the tick; the LFSR steps only on phase wrap
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase  <= '0;
            lfsr   <= LFSR_SEED;
            sample <= SAMPLE_MID;
        end else begin
            if (clr || !en) begin
                phase <= '0;
                lfsr  <= LFSR_SEED;
            end else if (tick) begin
                phase <= sum[15:0];
                if (sum[16])
                    lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            end
            sample <= en ? shape(wave, phase, lfsr[7:0]) : SAMPLE_MID;
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Four-channel NCO tone generator: bus register file, sample-tick prescaler,
// phase-clear control and the channel voices.
module tone_gen
    import tone_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CLK_DIV = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  ch0,
    output logic [7:0]  ch1,
    output logic [7:0]  ch2,
    output logic [7:0]  ch3,
    output logic        tick
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] freq_r [N_CH];
    wave_e       wave_r [N_CH];
    logic        en_r   [N_CH];
    logic [7:0]  samp   [N_CH];

    logic [2:0]  idx;
    logic        wr_en;
    logic        clr;
    logic [31:0] rd_mux;
    logic [15:0] div_cnt;
    logic        vld_p1;
    logic [31:0] rdata_p1;
    logic        unused_bits;

    assign idx         = addr[4:2];
    assign wr_en       = valid && (wstrb != 4'd0);
    assign clr         = wr_en && wstrb[0] && (idx == CTRL) && wdata[0];
    assign unused_bits = ^{addr[31:5], addr[1:0], wstrb[3], wdata[31:19]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                freq_r[i] <= '0;
                wave_r[i] <= SQUARE;
                en_r[i]   <= 1'b0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (idx == 3'(i)) begin
                    if (wstrb[0]) freq_r[i][7:0]  <= wdata[7:0];
                    if (wstrb[1]) freq_r[i][15:8] <= wdata[15:8];
                    if (wstrb[2]) begin
                        wave_r[i] <= wave_e'(wdata[17:16]);
                        en_r[i]   <= wdata[18];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == 3'(i))
                rd_mux = {13'd0, en_r[i], wave_r[i], freq_r[i]};
        end
    end

    // Bus response stage: acknowledge and read data one cycle after the request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1   <= valid;
            rdata_p1 <= (valid && wstrb == 4'd0) ? rd_mux : '0;
        end
    end

    assign ready = vld_p1;
    assign rdata = rdata_p1;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!resetn)
            div_cnt <= '0;
        else
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tone_channel u_ch (
            .clk    (clk),
            .resetn (resetn),
            .tick   (tick),
            .clr    (clr),
            .freq   (freq_r[g]),
            .wave   (wave_r[g]),
            .en     (en_r[g]),
            .sample (samp[g])
        );
    end

    assign ch0 = samp[0];
    assign ch1 = samp[1];
    assign ch2 = samp[2];
    assign ch3 = samp[3];

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen with a 4-cycle sample tick.
module tb_tone_gen;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        valid  = 1'b0;
    logic [3:0]  wstrb  = 4'd0;
    logic [31:0] addr   = 32'd0;
    logic [31:0] wdata  = 32'd0;
    logic        ready;
    logic [31:0] rdata;
    logic [7:0]  ch0, ch1, ch2, ch3;
    logic        tick;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_tab [4][8];
    logic [7:0] prev    [4];
    logic [7:0] got     [4];

    always #5 clk = ~clk;

    tone_gen #(.N_CH(4), .CLK_DIV(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ch0    (ch0),
        .ch1    (ch1),
        .ch2    (ch2),
        .ch3    (ch3),
        .tick   (tick)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'd0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        valid = 1'b1; addr = a; wstrb = 4'd0;
        @(negedge clk);
        check_val({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        check_val(tag, rdata, exp);
        valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where tick is high
    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic sample_all();
        got[0] = ch0; got[1] = ch1; got[2] = ch2; got[3] = ch3;
    endtask

    initial begin
        int n;
        exp_tab[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_tab[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        exp_tab[2] = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10};
        exp_tab[3] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00};

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check_val("rst_ch0", {24'd0, ch0}, 32'h80);
        check_val("rst_ch1", {24'd0, ch1}, 32'h80);
        check_val("rst_ch2", {24'd0, ch2}, 32'h80);
        check_val("rst_ch3", {24'd0, ch3}, 32'h80);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_tick", {31'd0, tick}, 32'd0);
        bus_read("rd_ch0_rst", 32'h00, 32'd0);

        bus_write(32'h00, 32'h0005_0100, 4'hF);
        bus_write(32'h04, 32'h0004_4000, 4'hF);
        bus_write(32'h08, 32'h0007_8000, 4'hF);
        bus_write(32'h0C, 32'h0006_2000, 4'hF);
        bus_write(32'h10, 32'h0000_0001, 4'hF);
        prev = '{8'h00, 8'h00, 8'h01, 8'h00};

        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            if (k > 0) check_val($sformatf("tick_period_%0d", k), n, 32'd2);
            @(negedge clk);
            check_val("tick_width", {31'd0, tick}, 32'd0);
            sample_all();
            for (int c = 0; c < 4; c++)
                check_val($sformatf("hold_ch%0d_t%0d", c, k), {24'd0, got[c]}, {24'd0, prev[c]});
            @(negedge clk);
            sample_all();
            for (int c = 0; c < 4; c++) begin
                check_val($sformatf("ch%0d_t%0d", c, k), {24'd0, got[c]}, {24'd0, exp_tab[c][k]});
                prev[c] = exp_tab[c][k];
            end
        end

        // Phase clear landing in the tick cycle
        wait_tick(n);
        valid = 1'b1; addr = 32'h10; wdata = 32'h1; wstrb = 4'h1;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'd0;
        @(negedge clk);
        check_val("clr_ch0", {24'd0, ch0}, 32'h00);
        check_val("clr_ch2", {24'd0, ch2}, 32'h01);
        check_val("clr_ch3", {24'd0, ch3}, 32'h00);
        wait_tick(n);
        repeat (2) @(negedge clk);
        check_val("clr_next_ch0", {24'd0, ch0}, 32'h01);
        check_val("clr_next_ch3", {24'd0, ch3}, 32'h40);

        bus_write(32'h00, 32'h0, 4'b0100);
        @(negedge clk);
        check_val("dis_ch0", {24'd0, ch0}, 32'h80);

        bus_read("rd_ch0", 32'h00, 32'h0000_0100);
        bus_read("rd_ch1", 32'h04, 32'h0004_4000);
        bus_read("rd_ch2", 32'h08, 32'h0007_8000);
        bus_read("rd_ch3", 32'h0C, 32'h0006_2000);
        bus_read("rd_ctrl", 32'h10, 32'h0);
        bus_read("rd_r5", 32'h14, 32'h0);
        bus_write(32'h00, 32'hFFFF_FF42, 4'b0001);
        bus_read("rd_strb0", 32'h00, 32'h0000_0142);
        bus_write(32'h00, 32'hFFFF_FFFF, 4'b1000);
        bus_read("rd_strb3", 32'h00, 32'h0000_0142);
        bus_write(32'h18, 32'hFFFF_FFFF, 4'hF);
        bus_read("rd_r6", 32'h18, 32'h0);

        // Read in the cycle right after a write to the same register
        @(negedge clk);
        valid = 1'b1; addr = 32'h04; wdata = 32'h0000_1234; wstrb = 4'b0011;
        @(negedge clk);
        wstrb = 4'd0;
        @(negedge clk);
        check_val("raw_rdy", {31'd0, ready}, 32'd1);
        check_val("raw_rdata", rdata, 32'h0004_1234);
        valid = 1'b0;

        // Reset in the middle of running tones, with a read in flight
        repeat (3) @(negedge clk);
        valid = 1'b1; addr = 32'h08; wstrb = 4'd0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        resetn = 1'b1;
        check_val("mrst_ch0", {24'd0, ch0}, 32'h80);
        check_val("mrst_ch1", {24'd0, ch1}, 32'h80);
        check_val("mrst_ch2", {24'd0, ch2}, 32'h80);
        check_val("mrst_ch3", {24'd0, ch3}, 32'h80);
        check_val("mrst_ready", {31'd0, ready}, 32'd0);
        check_val("mrst_rdata", rdata, 32'd0);
        bus_read("mrst_rd_ch1", 32'h04, 32'h0);
        bus_read("mrst_rd_ch2", 32'h08, 32'h0);
        bus_read("mrst_rd_ch3", 32'h0C, 32'h0);
        repeat (12) @(negedge clk);
        check_val("mrst_idle_ch1", {24'd0, ch1}, 32'h80);
        check_val("mrst_idle_ch2", {24'd0, ch2}, 32'h80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
